// File: rtl/fma16_pkg.sv
// Shared types and constants for the half-precision FMA rounding stage.
package fma16_pkg;
  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RM  = 2'b10,
    RP  = 2'b11
  } roundmode_t;

  typedef enum logic [1:0] {
    NSIG_NONE = 2'b00,
    NSIG_PROD = 2'b01,
    NSIG_ADD  = 2'b10
  } nsig_t;

  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] MAX_FIN = 16'h7BFF;
  localparam int          BIAS    = 15;
endpackage

// File: rtl/fma16_rnd_decide.sv
// Rounding decision: increment/decrement of the truncated magnitude and the inexact flag.
module fma16_rnd_decide
  import fma16_pkg::*;
(
  input  logic       i_l0,
  input  logic       i_g,
  input  logic       i_s,
  input  logic       i_sign,
  input  logic       i_ksign,
  input  nsig_t      i_nsig,
  input  roundmode_t i_rm,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_nx
);
  always_comb begin
    o_inc = 1'b0;
    o_dec = 1'b0;
    o_nx  = 1'b0;
    if (i_nsig == NSIG_NONE) begin
      o_nx = i_g | i_s;
      case (i_rm)
        RNE:     o_inc = i_g & (i_s | i_l0);
        RM:      o_inc = i_sign & (i_g | i_s);
        RP:      o_inc = ~i_sign & (i_g | i_s);
        default: o_inc = 1'b0;
      endcase
    end else begin
      // Killed operand is a tiny nudge above or below |sum| depending on its sign.
      o_nx = 1'b1;
      if (i_ksign == i_sign)
        o_inc = ((i_rm == RP) & ~i_sign) | ((i_rm == RM) & i_sign);
      else
        o_dec = (i_rm == RZ) | ((i_rm == RP) & i_sign) | ((i_rm == RM) & ~i_sign);
    end
  end
endmodule

// File: rtl/fma16_round.sv
// Two-stage valid/ready rounding stage producing binary16 results, flags and an inexact count.
module fma16_round
  import fma16_pkg::*;
#(
  parameter int NE   = 5,
  parameter int NF   = 10,
  parameter int SW   = 34,
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NE+NF:0]   sum,
  input  logic [SW-1:0]    fullSum,
  input  logic [1:0]       nSigFlag,
  input  logic             ksign,
  input  logic [1:0]       roundmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NE+NF:0]   result,
  output logic [1:0]       flags,
  output logic [CNTW-1:0]  nx_count
);
  localparam int MW = NE + NF;

  logic            r_s1_valid, r_s2_valid;
  logic [MW:0]     r_sum;
  logic            r_l0, r_g, r_s, r_zero, r_ksign;
  nsig_t           r_nsig;
  roundmode_t      r_rm;
  logic [MW:0]     r_result;
  logic [1:0]      r_flags;
  logic [CNTW-1:0] r_nx_count;

  logic            w_en2, w_sign, w_inc, w_dec, w_nx, w_of, w_inf;
  logic [MW-1:0]   w_r;
  logic [MW:0]     w_res;
  logic [1:0]      w_flg;

  assign w_en2     = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_en2;
  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign nx_count  = r_nx_count;

  // Only the rounding-relevant reductions of the significand are kept in stage 1.
  always_ff @(posedge clk) begin
    if (in_valid & in_ready) begin
      r_sum   <= sum;
      r_l0    <= fullSum[SW-1-NF];
      r_g     <= fullSum[SW-2-NF];
      r_s     <= |fullSum[SW-3-NF:0];
      r_zero  <= (fullSum == '0);
      r_nsig  <= nsig_t'(nSigFlag);
      r_ksign <= ksign;
      r_rm    <= roundmode_t'(roundmode);
    end
  end

  assign w_sign = r_sum[MW];

  fma16_rnd_decide u_decide (
    .i_l0    (r_l0),
    .i_g     (r_g),
    .i_s     (r_s),
    .i_sign  (w_sign),
    .i_ksign (r_ksign),
    .i_nsig  (r_nsig),
    .i_rm    (r_rm),
    .o_inc   (w_inc),
    .o_dec   (w_dec),
    .o_nx    (w_nx)
  );

  // Fraction carry ripples into the exponent through the plain magnitude add.
  assign w_r   = r_sum[MW-1:0] + MW'(w_inc) - MW'(w_dec);
  assign w_of  = &w_r[MW-1:NF];
  assign w_inf = (r_rm == RNE) | ((r_rm == RP) & ~w_sign) | ((r_rm == RM) & w_sign);

  always_comb begin
    w_res = {w_sign, w_r};
    w_flg = {1'b0, w_nx};
    if (r_zero && (r_nsig == NSIG_NONE)) begin
      w_res = r_sum;
      w_flg = 2'b00;
    end else if (w_of) begin
      w_res = {w_sign, (w_inf ? POS_INF[MW-1:0] : MAX_FIN[MW-1:0])};
      w_flg = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_nx_count <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_en2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result <= w_res;
          r_flags  <= w_flg;
        end
      end
      if (r_s2_valid & out_ready & r_flags[0] & ~&r_nx_count)
        r_nx_count <= r_nx_count + 1'b1;
    end
  end
endmodule
